// File: rtl/hazard_pkg.sv
// Shared constants for the ID->EXE hazard scheduler: register-file size,
// scoreboard counter width and the stall latencies charged per mode.
package hazard_pkg;

  localparam int NREG      = 16;
  localparam int IDX_W     = $clog2(NREG);
  localparam int CNT_W     = 2;
  localparam int LAT_LDFWD = 1;
  localparam int LAT_NOFWD = 2;
  localparam int PERF_W    = 16;

  typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage instruction descriptor plus the scheduler's per-cycle decisions.
// master = decode stage (drives the descriptor), slave = scheduler.
interface hazard_scheduler_if #(
  parameter int IDX_W = hazard_pkg::IDX_W
);

  logic             id_valid;
  logic [IDX_W-1:0] id_src1;
  logic [IDX_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic [IDX_W-1:0] id_dest;
  logic             hazard;
  logic             issue;
  logic             flush_id;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
    input  hazard, issue, flush_id
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
    output hazard, issue, flush_id
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: cycles until the pending result for this register is
// visible to ID. A new charge overrides the decrement of the same cycle.
module hazard_sb_entry #(
  parameter int CNT_W = hazard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             charge,
  input  logic [CNT_W-1:0] charge_val,
  input  logic             dec_en,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_reg;

  // Counter: load on charge, otherwise count down to zero while the pipe moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (charge) begin
      cnt_reg <= charge_val;
    end else if (dec_en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Issue/stall scheduler for the ID->EXE boundary. Looks up the source
// registers of the ID instruction in a scoreboard of down-counters, raises
// hazard while any source is still in flight, and charges the destination
// register when a write-back instruction issues.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int NREG      = hazard_pkg::NREG,
  parameter int CNT_W     = hazard_pkg::CNT_W,
  parameter int LAT_LDFWD = hazard_pkg::LAT_LDFWD,
  parameter int LAT_NOFWD = hazard_pkg::LAT_NOFWD,
  parameter int PERF_W    = hazard_pkg::PERF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Forward_En,
  input  logic              mem_freeze,
  input  logic              branch_taken,
  input  logic              perf_clr,
  hazard_scheduler_if.slave id_bus,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [CNT_W-1:0] LD_FWD_VAL = CNT_W'(LAT_LDFWD);
  localparam logic [CNT_W-1:0] NO_FWD_VAL = CNT_W'(LAT_NOFWD);

  logic [NREG-1:0]   busy;
  logic              raw;
  logic              hazard_c;
  logic              issue_c;
  logic              charge_en;
  logic [CNT_W-1:0]  charge_val;
  logic [PERF_W-1:0] stall_cycles_reg;

  // Hazard/issue decision on start-of-cycle scoreboard state. The source
  // lookup uses registered counters, so an instruction that reads its own
  // destination never blocks itself.
  always_comb begin
    raw      = id_bus.id_valid &
               (busy[id_bus.id_src1] | (id_bus.id_two_src & busy[id_bus.id_src2]));
    hazard_c = raw & ~branch_taken;
    issue_c  = id_bus.id_valid & ~hazard_c & ~branch_taken & ~mem_freeze;
  end

  assign id_bus.hazard   = hazard_c;
  assign id_bus.issue    = issue_c;
  assign id_bus.flush_id = branch_taken;

  // Charge decode: with forwarding only loads need a bubble; without it every
  // write-back must reach the register file first.
  always_comb begin
    charge_en  = issue_c & id_bus.id_wb_en & (~Forward_En | id_bus.id_mem_r_en);
    charge_val = Forward_En ? LD_FWD_VAL : NO_FWD_VAL;
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    hazard_sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .charge     (charge_en && (id_bus.id_dest == IDX_W'(gi))),
      .charge_val (charge_val),
      .dec_en     (~mem_freeze),
      .busy       (busy[gi])
    );
  end

  // Stall-cycle counter: counts real (unfrozen) bubbles, saturates, clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
    end else if (perf_clr) begin
      stall_cycles_reg <= '0;
    end else if (hazard_c && !mem_freeze && !(&stall_cycles_reg)) begin
      stall_cycles_reg <= stall_cycles_reg + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler. A default instance (PERF_W=16) and a
// narrow one (PERF_W=4) see identical stimulus; the narrow one exposes
// stall-counter saturation within a short run.
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic fwd_en, mem_freeze, branch_taken, perf_clr;
  logic id_valid, id_two_src, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic [15:0] stall0;
  logic [3:0]  stall1;
  logic [2:0]  obs0, obs1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scheduler_if #(.IDX_W(4)) bus0 ();
  hazard_scheduler_if #(.IDX_W(4)) bus1 ();

  assign bus0.id_valid = id_valid;    assign bus1.id_valid = id_valid;
  assign bus0.id_src1 = id_src1;      assign bus1.id_src1 = id_src1;
  assign bus0.id_src2 = id_src2;      assign bus1.id_src2 = id_src2;
  assign bus0.id_two_src = id_two_src; assign bus1.id_two_src = id_two_src;
  assign bus0.id_wb_en = id_wb_en;    assign bus1.id_wb_en = id_wb_en;
  assign bus0.id_mem_r_en = id_mem_r_en; assign bus1.id_mem_r_en = id_mem_r_en;
  assign bus0.id_dest = id_dest;      assign bus1.id_dest = id_dest;

  // {hazard, issue, flush_id}
  assign obs0 = {bus0.hazard, bus0.issue, bus0.flush_id};
  assign obs1 = {bus1.hazard, bus1.issue, bus1.flush_id};

  hazard_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .Forward_En(fwd_en), .mem_freeze(mem_freeze),
    .branch_taken(branch_taken), .perf_clr(perf_clr), .id_bus(bus0), .stall_cycles(stall0)
  );

  hazard_scheduler #(.PERF_W(4)) u_dut_narrow (
    .clk(clk), .rst_n(rst_n), .Forward_En(fwd_en), .mem_freeze(mem_freeze),
    .branch_taken(branch_taken), .perf_clr(perf_clr), .id_bus(bus1), .stall_cycles(stall1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic ld, input logic [3:0] d);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fwd_en = 1'b1; mem_freeze = 1'b0; branch_taken = 1'b0; perf_clr = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    settle();
    checks++; if (obs0 !== 3'b000) begin errors++; $display("FAIL reset_outs got %b want %b", obs0, 3'b000); end
    checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall0); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_load();
    fwd_en = 1'b1;
    set_id(1, 0, 0, 0, 1, 1, 2); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL ld_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 2, 4, 1, 1, 0, 3); settle();
    checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL ld_use_stall got %b want %b", obs0, 3'b100); end
    tick(); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL ld_use_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd1) begin errors++; $display("FAIL ld_stall_cnt got %0d want 1", stall0); end
    tick();
  endtask

  task automatic test_fwd_alu();
    set_id(1, 0, 0, 0, 1, 0, 5); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL alu_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 5, 5, 1, 1, 0, 6); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL alu_b2b got %b want %b", obs0, 3'b010); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd1) begin errors++; $display("FAIL alu_stall_cnt got %0d want 1", stall0); end
    tick();
  endtask

  task automatic test_nofwd_alu();
    fwd_en = 1'b0;
    set_id(1, 0, 0, 0, 1, 0, 1); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL nf_wr_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 3, 1, 1, 1, 0, 6);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL nf_stall%0d got %b want %b", i, obs0, 3'b100); end
      tick();
    end
    settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL nf_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd3) begin errors++; $display("FAIL nf_stall_cnt got %0d want 3", stall0); end
    tick(); tick();
  endtask

  task automatic test_freeze();
    set_id(1, 0, 0, 0, 1, 1, 7); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL fz_ld_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 7, 0, 0, 0, 0, 8); mem_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL fz_hold%0d got %b want %b", i, obs0, 3'b100); end
      tick();
    end
    checks++; if (stall0 !== 16'd3) begin errors++; $display("FAIL fz_no_count got %0d want 3", stall0); end
    mem_freeze = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL fz_stall%0d got %b want %b", i, obs0, 3'b100); end
      tick();
    end
    settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL fz_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd5) begin errors++; $display("FAIL fz_stall_cnt got %0d want 5", stall0); end
    tick();
  endtask

  task automatic test_branch();
    set_id(1, 0, 0, 0, 1, 0, 9); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL br_wr_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 9, 0, 0, 1, 0, 10); branch_taken = 1'b1; settle();
    checks++; if (obs0 !== 3'b001) begin errors++; $display("FAIL br_squash got %b want %b", obs0, 3'b001); end
    tick();
    branch_taken = 1'b0;
    set_id(1, 10, 0, 0, 0, 0, 0); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL br_no_charge got %b want %b", obs0, 3'b010); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd5) begin errors++; $display("FAIL br_stall_cnt got %0d want 5", stall0); end
    tick();
  endtask

  task automatic test_self_and_mode();
    fwd_en = 1'b0;
    set_id(1, 11, 11, 1, 1, 0, 11); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL self_issue got %b want %b", obs0, 3'b010); end
    tick();
    fwd_en = 1'b1;
    set_id(1, 11, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL mode_stall%0d got %b want %b", i, obs0, 3'b100); end
      tick();
    end
    settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL mode_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 0, 0, 0, 1, 0, 12); tick();
    set_id(1, 12, 0, 0, 0, 0, 0); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL mode_fwd_alu got %b want %b", obs0, 3'b010); end
    tick();
    fwd_en = 1'b0;
  endtask

  task automatic test_charge_wins();
    set_id(1, 0, 0, 0, 1, 0, 13); tick();
    set_id(1, 0, 0, 0, 1, 0, 13); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL cw_rewrite got %b want %b", obs0, 3'b010); end
    tick();
    set_id(1, 13, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL cw_stall%0d got %b want %b", i, obs0, 3'b100); end
      tick();
    end
    settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL cw_issue got %b want %b", obs0, 3'b010); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd9) begin errors++; $display("FAIL cw_stall_cnt got %0d want 9", stall0); end
    tick();
  endtask

  task automatic test_saturation();
    perf_clr = 1'b1; tick(); perf_clr = 1'b0; settle();
    checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", stall0); end
    checks++; if (stall1 !== 4'd0) begin errors++; $display("FAIL sat_clr_n got %0d want 0", stall1); end
    tick();
    for (int i = 0; i < 8; i++) begin
      set_id(1, 0, 0, 0, 1, 0, 1); tick();
      set_id(1, 1, 0, 0, 0, 0, 0); tick(); tick(); tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0); settle();
    checks++; if (stall0 !== 16'd16) begin errors++; $display("FAIL sat_wide got %0d want 16", stall0); end
    checks++; if (stall1 !== 4'hF) begin errors++; $display("FAIL sat_narrow got %0d want 15", stall1); end
    tick();
  endtask

  task automatic test_perf_clr();
    set_id(1, 0, 0, 0, 1, 0, 2); tick();
    set_id(1, 2, 0, 0, 0, 0, 0); perf_clr = 1'b1; settle();
    checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL pc_stall got %b want %b", obs0, 3'b100); end
    tick();
    perf_clr = 1'b0; settle();
    checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL pc_clear got %0d want 0", stall0); end
    checks++; if (obs1 !== 3'b100) begin errors++; $display("FAIL pc_narrow_stall got %b want %b", obs1, 3'b100); end
    tick(); settle();
    checks++; if (stall0 !== 16'd1) begin errors++; $display("FAIL pc_recount got %0d want 1", stall0); end
    checks++; if (stall1 !== 4'd1) begin errors++; $display("FAIL pc_recount_n got %0d want 1", stall1); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_mid();
    set_id(1, 0, 0, 0, 1, 0, 14); tick();
    set_id(1, 14, 0, 0, 0, 0, 0); settle();
    checks++; if (obs0 !== 3'b100) begin errors++; $display("FAIL rm_stall got %b want %b", obs0, 3'b100); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL rm_async got %b want %b", obs0, 3'b010); end
    checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d want 0", stall0); end
    #1 rst_n = 1'b1;
    tick(); settle();
    checks++; if (obs0 !== 3'b010) begin errors++; $display("FAIL rm_after got %b want %b", obs0, 3'b010); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fwd_load();
    test_fwd_alu();
    test_nofwd_alu();
    test_freeze();
    test_branch();
    test_self_and_mode();
    test_charge_wins();
    test_saturation();
    test_perf_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
